// File: rtl/instr_encoder_pkg.sv
// MIPS opcode/function declarations and the field bundle fed to instr_pack.
package mips_decls_p;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_ORI   = 6'h0D,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_t;

    typedef enum logic [5:0] {
        F_ADD = 6'h20,
        F_SUB = 6'h22,
        F_AND = 6'h24,
        F_OR  = 6'h25,
        F_SLT = 6'h2A
    } funct_t;

    typedef struct packed {
        opcode_t     op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
    } instr_fields_t;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational field packer: selects the R/I/J layout by opcode and flags unknown opcodes.
module instr_pack
    import mips_decls_p::*;
(
    input  instr_fields_t f,
    output logic [31:0]   word,
    output logic          legal
);

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (f.op)
            OP_RTYPE:                                  word = {f.op, f.rs, f.rt, f.rd, f.shamt, f.funct};
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI: word = {f.op, f.rs, f.rt, f.imm};
            OP_J:                                      word = {f.op, f.target};
            default:                                   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction fields and writes them sequentially into instruction memory,
// one word every two cycles, stopping when the memory is full.
module instr_encoder
    import mips_decls_p::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  opcode_t           opcode,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FULL} state_t;

    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   CAP  = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    logic [ADDR_W-1:0] addr;
    instr_fields_t     fields;
    logic [31:0]       word;
    logic              legal;

    assign fields = '{op: opcode, rs: rs, rt: rt, rd: rd, shamt: shamt,
                      funct: funct, imm: imm, target: target};

    instr_pack u_pack (
        .f     (fields),
        .word  (word),
        .legal (legal)
    );

    // clear wins over both a pending request and an in-flight write strobe
    assign req_ready = (state == S_IDLE) && !clear;
    assign wr_en     = (state == S_WRITE) && !clear;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            addr    <= '0;
            count   <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            full    <= 1'b0;
            err     <= 1'b0;
        end else begin
            err <= 1'b0;
            if (clear) begin
                state <= S_IDLE;
                addr  <= '0;
                count <= '0;
                full  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (req_valid) begin
                        if (legal) begin
                            wr_addr <= addr;
                            wr_data <= word;
                            state   <= S_WRITE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    S_WRITE: begin
                        if (count != CAP) count <= count + 1'b1;
                        // hold the address at the top rather than wrapping
                        if (addr == LAST) begin
                            state <= S_FULL;
                            full  <= 1'b1;
                        end else begin
                            addr  <= addr + 1'b1;
                            state <= S_IDLE;
                        end
                    end
                    S_FULL:  ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding table, illegal opcode, fill-to-full, clear/reset mid-write.
module tb_instr_encoder;
    import mips_decls_p::*;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              reset, clear, req_valid, req_ready;
    opcode_t           opcode;
    logic [4:0]        rs, rt, rd, shamt;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              wr_en, full, err;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [ADDR_W:0]   count;

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm(imm), .target(target), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .count(count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        opcode_t     op;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
        logic [31:0] exp_word;
        logic        exp_legal;
    } vec_t;

    int pass_cnt = 0;
    int total    = 0;
    int mcount   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(opcode_t op, logic [4:0] s, logic [4:0] t, logic [4:0] d,
                                logic [4:0] sh, logic [5:0] fn, logic [15:0] im,
                                logic [25:0] tg, logic [31:0] w, logic lg);
        vec_t v;
        v.op = op; v.rs = s; v.rt = t; v.rd = d; v.shamt = sh; v.funct = fn;
        v.imm = im; v.target = tg; v.exp_word = w; v.exp_legal = lg;
        return v;
    endfunction

    // Presents one request at a negedge; returns at the negedge of the following cycle.
    task automatic send(input vec_t v);
        @(negedge clk);
        opcode = v.op; rs = v.rs; rt = v.rt; rd = v.rd; shamt = v.shamt;
        funct = v.funct; imm = v.imm; target = v.target;
        req_valid = 1'b1;
        #1 chk("req_ready_before_send", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic send_check(input vec_t v, input int exp_addr);
        send(v);
        if (v.exp_legal) begin
            chk("wr_en_pulse", wr_en, 1);
            chk("wr_addr", wr_addr, exp_addr);
            chk("wr_data", wr_data, v.exp_word);
            chk("req_ready_in_write", req_ready, 0);
            @(negedge clk);
            mcount++;
            chk("wr_en_off", wr_en, 0);
            chk("count", count, mcount);
        end else begin
            chk("err_pulse", err, 1);
            chk("no_wr_en_illegal", wr_en, 0);
            @(negedge clk);
            chk("err_single_cycle", err, 0);
            chk("count_unchanged", count, mcount);
        end
    endtask

    vec_t tbl[9];
    vec_t addi5, rtyp, lw4;
    int   nwr;

    initial begin
        tbl[0] = mk(OP_ADDI,  5'd0,  5'd8,  5'd0,  5'd0, 6'h00, 16'h0005, 26'h0, 32'h20080005, 1'b1);
        tbl[1] = mk(OP_BEQ,   5'd1,  5'd2,  5'd7,  5'd3, 6'h11, 16'hFFFF, 26'h0, 32'h1022FFFF, 1'b1);
        tbl[2] = mk(OP_J,     5'd9,  5'd9,  5'd9,  5'd9, 6'h3F, 16'hAAAA, 26'h10, 32'h08000010, 1'b1);
        tbl[3] = mk(OP_BNE,   5'd3,  5'd4,  5'd0,  5'd0, 6'h00, 16'h1234, 26'h0, 32'h14641234, 1'b1);
        tbl[4] = mk(OP_SW,    5'd29, 5'd31, 5'd1,  5'd1, 6'h01, 16'h0008, 26'h0, 32'hAFBF0008, 1'b1);
        tbl[5] = mk(OP_ORI,   5'd5,  5'd6,  5'd0,  5'd0, 6'h00, 16'hABCD, 26'h3FFFFFF, 32'h34A6ABCD, 1'b1);
        tbl[6] = mk(opcode_t'(6'h3F), 5'd1, 5'd1, 5'd1, 5'd1, 6'h20, 16'h1, 26'h1, 32'h0, 1'b0);
        tbl[7] = mk(OP_RTYPE, 5'd8,  5'd9,  5'd16, 5'd0, 6'h20, 16'hFFFF, 26'h0, 32'h01098020, 1'b1);
        tbl[8] = mk(OP_LW,    5'd29, 5'd10, 5'd0,  5'd0, 6'h00, 16'h0004, 26'h0, 32'h8FAA0004, 1'b1);
        addi5 = tbl[0]; rtyp = tbl[7]; lw4 = tbl[8];

        reset = 1'b1; clear = 1'b0; req_valid = 1'b0; opcode = OP_RTYPE;
        rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0; imm = '0; target = '0;
        #12;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_count", count, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_full", full, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("ready_after_reset", req_ready, 1);

        // table: each legal entry lands at the next address
        for (int i = 0; i < 9; i++) send_check(tbl[i], mcount);

        // fresh program: RTYPE then LW at addresses 0 and 1
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0; mcount = 0;
        chk("clear_count", count, 0);
        send_check(rtyp, 0);
        send_check(lw4, 1);

        // fill all 64 words with valid held high
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0; mcount = 0;
        opcode = addi5.op; rs = addi5.rs; rt = addi5.rt; imm = addi5.imm;
        req_valid = 1'b1;
        nwr = 0;
        for (int c = 0; c < 140; c++) begin
            @(negedge clk);
            if (wr_en) begin
                if (wr_addr != nwr[ADDR_W-1:0])
                    chk("fill_addr_seq", wr_addr, nwr);
                nwr++;
            end
        end
        chk("fill_writes", nwr, 64);
        chk("fill_full", full, 1);
        chk("fill_ready_low", req_ready, 0);
        chk("fill_count_sat", count, 64);
        chk("fill_last_addr", wr_addr, 63);
        chk("fill_wr_en_off", wr_en, 0);
        clear = 1'b1;
        #1 chk("clear_forces_ready_low", req_ready, 0);
        @(negedge clk);
        clear = 1'b0; req_valid = 1'b0;
        #1;
        chk("after_clear_count", count, 0);
        chk("after_clear_full", full, 0);
        chk("after_clear_ready", req_ready, 1);

        // clear during the write cycle
        send(addi5);
        clear = 1'b1;
        #1 chk("clear_mid_write_no_wr_en", wr_en, 0);
        @(negedge clk); clear = 1'b0;
        chk("clear_mid_write_count", count, 0);
        mcount = 0;
        send_check(tbl[3], 0);

        // reset during the write cycle
        send(addi5);
        reset = 1'b1;
        #1 chk("reset_mid_write_no_wr_en", wr_en, 0);
        @(negedge clk); reset = 1'b0;
        #1;
        chk("reset_mid_write_count", count, 0);
        chk("reset_mid_write_wr_addr", wr_addr, 0);
        chk("reset_mid_write_ready", req_ready, 1);
        mcount = 0;
        send_check(tbl[5], 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
